// File: rtl/countdown_timer.sv
// Loadable HH:MM:SS countdown timer clocked by a 1 Hz enable clock.
// Pulses expired on reaching 00:00:00; either stops in DONE or auto-reloads.
module countdown_timer #(
  parameter int unsigned MAX_HOURS   = 23,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  input  logic       start,
  input  logic       pause,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t     state, state_n;
  logic [4:0] hrs_n, ld_hrs, rl_hrs;
  logic [5:0] min_n, ld_min, rl_min;
  logic [5:0] sec_n, ld_sec, rl_sec;
  logic       expired_n;
  logic       cnt_zero, at_one, rl_zero;

  always_comb begin
    ld_hrs = (load_hours   > 5'(MAX_HOURS)) ? 5'(MAX_HOURS) : load_hours;
    ld_min = (load_minutes > 6'd59)         ? 6'd59         : load_minutes;
    ld_sec = (load_seconds > 6'd59)         ? 6'd59         : load_seconds;
  end

  assign cnt_zero = (hours == '0) && (minutes == '0) && (seconds == '0);
  assign at_one   = (hours == '0) && (minutes == '0) && (seconds == 6'd1);
  assign rl_zero  = (rl_hrs == '0) && (rl_min == '0) && (rl_sec == '0);

  always_ff @(posedge Clk_1sec) begin
    if (reset) begin
      state   <= IDLE;
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
      rl_hrs  <= '0;
      rl_min  <= '0;
      rl_sec  <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      hours   <= hrs_n;
      minutes <= min_n;
      seconds <= sec_n;
      expired <= expired_n;
      if (load) begin
        rl_hrs <= ld_hrs;
        rl_min <= ld_min;
        rl_sec <= ld_sec;
      end
    end
  end

  always_comb begin
    state_n   = state;
    hrs_n     = hours;
    min_n     = minutes;
    sec_n     = seconds;
    expired_n = 1'b0;
    if (load) begin
      hrs_n   = ld_hrs;
      min_n   = ld_min;
      sec_n   = ld_sec;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // pause outranks start, so a simultaneous pair does not launch a run
          if (!pause && start && !cnt_zero) state_n = RUN;
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (cnt_zero) begin
            state_n = DONE;
          end else if (at_one) begin
            expired_n = 1'b1;
            if (AUTO_RELOAD && !rl_zero) begin
              hrs_n = rl_hrs;
              min_n = rl_min;
              sec_n = rl_sec;
            end else begin
              hrs_n   = '0;
              min_n   = '0;
              sec_n   = '0;
              state_n = DONE;
            end
          end else if (seconds != '0) begin
            sec_n = seconds - 6'd1;
          end else if (minutes != '0) begin
            sec_n = 6'd59;
            min_n = minutes - 6'd1;
          end else begin
            sec_n = 6'd59;
            min_n = 6'd59;
            hrs_n = hours - 5'd1;
          end
        end
        PAUSED: begin
          if (!pause && start) state_n = RUN;
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer: a stop-on-expiry instance
// and an auto-reload instance share the same stimulus.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, load, start, pause;
  logic [4:0] load_hours;
  logic [5:0] load_minutes, load_seconds;

  logic [4:0] hours, ar_hours;
  logic [5:0] minutes, seconds, ar_minutes, ar_seconds;
  logic       running, done, expired, ar_running, ar_done, ar_expired;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  countdown_timer #(.MAX_HOURS(23), .AUTO_RELOAD(1'b0)) dut (
    .Clk_1sec(clk), .reset(reset), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .start(start), .pause(pause),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .running(running), .done(done), .expired(expired)
  );

  countdown_timer #(.MAX_HOURS(23), .AUTO_RELOAD(1'b1)) dut_ar (
    .Clk_1sec(clk), .reset(reset), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .start(start), .pause(pause),
    .hours(ar_hours), .minutes(ar_minutes), .seconds(ar_seconds),
    .running(ar_running), .done(ar_done), .expired(ar_expired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hms(input int h, input int m, input int s);
    return 32'(h * 3600 + m * 60 + s);
  endfunction

  function automatic logic [31:0] cnt();
    return 32'(hours) * 3600 + 32'(minutes) * 60 + 32'(seconds);
  endfunction

  function automatic logic [31:0] ar_cnt();
    return 32'(ar_hours) * 3600 + 32'(ar_minutes) * 60 + 32'(ar_seconds);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load_hours   = 5'(h);
    load_minutes = 6'(m);
    load_seconds = 6'(s);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int pulses;
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_hours = '0; load_minutes = '0; load_seconds = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_count", cnt(), 0);
    chk("reset_running", 32'(running), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_expired", 32'(expired), 0);

    // Saturating load
    do_load(31, 63, 60);
    chk("clamp_count", cnt(), hms(23, 59, 59));
    chk("clamp_running", 32'(running), 0);

    // Hour borrow
    do_load(1, 0, 0);
    do_start();
    chk("h_start_running", 32'(running), 1);
    chk("h_start_count", cnt(), hms(1, 0, 0));
    tick();
    chk("h_borrow", cnt(), hms(0, 59, 59));
    tick();
    chk("h_next", cnt(), hms(0, 59, 58));

    // Minute borrow
    do_load(0, 1, 0);
    do_start();
    tick();
    chk("m_borrow", cnt(), hms(0, 0, 59));

    // Full run to expiry
    do_load(0, 1, 5);
    do_start();
    pulses = 0;
    repeat (64) begin
      tick();
      pulses += int'(expired);
    end
    chk("run64_count", cnt(), 1);
    chk("run64_no_pulse", 32'(pulses), 0);
    tick();
    chk("exp_count", cnt(), 0);
    chk("exp_pulse", 32'(expired), 1);
    chk("exp_done", 32'(done), 1);
    chk("exp_running", 32'(running), 0);
    tick();
    chk("exp_pulse_end", 32'(expired), 0);
    chk("done_level", 32'(done), 1);
    do_start();
    chk("done_ignore_start", 32'(done), 1);
    chk("done_hold_count", cnt(), 0);

    // load+start together: load wins
    load_hours = 5'd0; load_minutes = 6'd0; load_seconds = 6'd5;
    load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    chk("ldstart_running", 32'(running), 0);
    chk("ldstart_done", 32'(done), 0);
    chk("ldstart_count", cnt(), 5);

    // Pause / resume
    do_load(0, 0, 12);
    do_start();
    tick();
    tick();
    chk("pre_pause", cnt(), 10);
    pause = 1'b1;
    tick();
    chk("pause_running", 32'(running), 0);
    repeat (4) tick();
    chk("pause_hold", cnt(), 10);
    start = 1'b1;
    tick();
    chk("pause_start_both", 32'(running), 0);
    pause = 1'b0;
    tick();
    start = 1'b0;
    chk("resume_running", 32'(running), 1);
    chk("resume_count", cnt(), 10);
    tick();
    chk("resume_dec", cnt(), 9);

    // Reset mid-run
    do_load(0, 30, 0);
    do_start();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_count", cnt(), 0);
    chk("midreset_running", 32'(running), 0);
    do_start();
    chk("zero_start_running", 32'(running), 0);
    chk("zero_start_count", cnt(), 0);

    // Auto reload
    do_load(0, 0, 3);
    do_start();
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("ar_count", ar_cnt(), (i % 3 == 0) ? 32'd3 : 32'(3 - (i % 3)));
      chk("ar_expired", 32'(ar_expired), (i % 3 == 0) ? 32'd1 : 32'd0);
      chk("ar_done", 32'(ar_done), 0);
      chk("ar_running", 32'(ar_running), 1);
      if (i == 3) chk("noar_done_at3", 32'(done), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
